bp_fe_fetch_ctrl: RTL and testbench
===================================

# bp_fe_fetch_ctrl

Parametrised front-end fetch controller that sits between the FE command channel, the I-cache fetch pipeline and the FE queue. It accepts multi-instruction fetch packets of `fetch_width_p` instructions and splits them into a single-instruction output buffer of `queue_els_p` entries. It tracks in-flight fetches with credits and drops stale responses after a redirect using an epoch bit. It generalises the single-instruction, unbuffered FE control loop to configurable fetch width, buffer depth and outstanding-request depth.

## Interface
- `vaddr_width_p`, 39: virtual PC width.
- `instr_width_p`, 32: instruction width.
- `fetch_width_p`, 2: instructions per fetch packet; power of two, ≥1.
- `queue_els_p`, 8: output buffer entries; must be ≥ `fetch_width_p`.
- `max_outstanding_p`, 2: maximum fetches in flight.
- `exc_code_width_p`, 2: exception code width.
- `clk_i` in 1: clock; single clock domain.
- `reset_i` in 1: reset, asynchronous and active-high.
- `cmd_v_i` in 1: FE command valid.
- `cmd_opcode_i` in 3: `e_op_*` FE command opcode.
- `cmd_pc_i` in `vaddr_width_p`: redirect target PC.
- `cmd_yumi_o` out 1: command consumed.
- `fetch_v_o` out 1: fetch request valid.
- `fetch_pc_o` out `vaddr_width_p`: fetch PC.
- `fetch_epoch_o` out 1: epoch tag for the request.
- `fetch_yumi_i` in 1: I-cache accepted the request.
- `resp_v_i` in 1: fetch response valid.
- `resp_epoch_i` in 1: epoch tag returned with the response.
- `resp_pc_i` in `vaddr_width_p`: PC of lane 0.
- `resp_instr_i` in `fetch_width_p*instr_width_p`: packet; lane 0 in the LSBs.
- `resp_count_i` in `clog2(fetch_width_p+1)`: valid lanes, 1..`fetch_width_p`, contiguous from lane 0.
- `resp_exc_v_i` in 1: response carries an exception.
- `resp_exc_code_i` in `exc_code_width_p`: exception code.
- `fe_queue_v_o` out 1: output entry valid.
- `fe_queue_pc_o` out `vaddr_width_p`: PC of the output entry.
- `fe_queue_instr_o` out `instr_width_p`: instruction of the output entry.
- `fe_queue_exc_v_o` out 1: output entry is an exception.
- `fe_queue_exc_code_o` out `exc_code_width_p`: exception code of the output entry.
- `fe_queue_yumi_i` in 1: consumer takes the head entry.

## Operation
- **States.**
  - `e_wait`: reset state.
  - `e_run`: fetching.
  - `redirect` = `cmd_v_i` with any opcode other than `e_op_attaboy`.
  - `e_wait`→`e_run` on redirect.
  - `e_run`→`e_wait` when an exception entry is enqueued and no redirect occurs in the same cycle.
  - A redirect in `e_run` stays in `e_run`.
- **Commands.**
  - `cmd_yumi_o = cmd_v_i` for every opcode; commands never stall.
  - Attaboy has no effect in this block.
- **Redirect, taking effect at the next clock edge:**
  - `pc_r ← cmd_pc_i`.
  - `epoch_r` toggles.
  - Buffer flushes to count 0.
  - Any response in the same cycle is dropped.
  - `fe_queue_v_o` is forced 0 and `fetch_v_o` is forced 0 in that cycle.
- **Issue rule.**
  - `fetch_v_o = is_run & ~redirect & (out_r < max_outstanding_p) & (count_r + fetch_width_p*(out_r+1) ≤ queue_els_p)`.
  - `fetch_pc_o = pc_r`; `fetch_epoch_o = epoch_r`.
- **PC advance.**
  - On `fetch_v_o & fetch_yumi_i`: `pc_r ← (pc_r & ~(4*fetch_width_p-1)) + 4*fetch_width_p`.
  - A misaligned redirect target therefore re-aligns after the first fetch.
- **Outstanding counter `out_r`.**
  - +1 on each accepted fetch; −1 on each `resp_v_i`, stale or not.
  - Both in the same cycle leave it unchanged.
  - It is not cleared on redirect.
- **Response.**
  - Accepted only if `resp_epoch_i == epoch_r` and no redirect is active.
  - Non-exception response: enqueue `resp_count_i` entries; lane *i* gets PC `resp_pc_i + 4i`.
  - Exception response: enqueue exactly one entry with `exc_v = 1`, PC `resp_pc_i`, instruction 0.
  - No response-side backpressure: the credit rule guarantees space. Overflow is an assertion failure.
- **Dequeue.**
  - `fe_queue_v_o = (count_r != 0) & ~redirect`.
  - The head entry is presented combinationally.
  - Dequeue happens on `fe_queue_yumi_i`, which is legal only while `fe_queue_v_o` is high.
- **Simultaneous events.** Enqueue of *n* and dequeue of 1 in one cycle: `count_r ← count_r + n − 1`.
- **Buffer.** Circular; read and write pointers wrap modulo `queue_els_p`.

## Timing
- **Reset values:** state `e_wait`; `count_r`, `out_r`, `epoch_r` and `pc_r` all 0.
- **Outputs during reset:** `fetch_v_o` = 0 and `fe_queue_v_o` = 0; `cmd_yumi_o` follows `cmd_v_i`.
- **Redirect to first fetch:** `fetch_v_o` rises 1 cycle after the redirect.
- **Response to output:** an enqueued entry is visible on `fe_queue_*` in the cycle after `resp_v_i`.
- **Reset asserted mid-operation:** all state clears immediately, without waiting for a clock edge.
- **Responses after reset:** in-flight responses arriving after reset are the environment's responsibility and are not accepted in `e_wait`.

## Structure
- **`bp_fe_pkg`** holds:
  - the `e_op_*` opcode enum;
  - the exception-code enum (`e_itlb_miss`, `e_icache_miss`, `e_instr_page_fault`, `e_instr_access_fault`);
  - the buffer-entry struct `{pc, instr, exc_v, exc_code}`.
- **`bp_fe_fetch_buffer`** is a natural sub-module:
  - circular buffer with a multi-write port (up to `fetch_width_p` entries per cycle) and a single read port;
  - exposes `count_o`;
  - provides a flush input.

## Test plan
Parameters for all scenarios: `fetch_width_p`=2, `queue_els_p`=8, `max_outstanding_p`=2.

1. Reset, then redirect to 0x8000_0000 with `fetch_yumi_i`=1:
   - all outputs 0 during reset;
   - `fetch_pc_o` is 0x8000_0000, then 0x8000_0008, then stalls at `out_r`=2 until responses return.
2. Redirect to 0x8000_0004; respond with count 1, instruction 0x13:
   - one entry with PC 0x8000_0004;
   - the next `fetch_pc_o` is 0x8000_0008.
3. Consumer holds `fe_queue_yumi_i`=0; return full packets:
   - after 4 responses, `count_r`=8 and `fetch_v_o` stays 0;
   - one dequeue does not re-enable fetch; once `count_r` reaches 6 with `out_r`=0, fetch re-enables.
4. Two fetches in flight, then redirect to 0x9000_0000; both old-epoch responses return:
   - both are dropped and the buffer stays empty;
   - `out_r` returns to 0;
   - `fetch_pc_o` becomes 0x9000_0000 the next cycle.
5. Response with `resp_exc_v_i`=1, code `e_icache_miss`:
   - one exception entry is enqueued;
   - state becomes `e_wait` and `fetch_v_o` stays 0 until the next redirect.
6. `count_r`=5 with a 2-lane response and `fe_queue_yumi_i`=1 in the same cycle:
   - `count_r` becomes 6;
   - entry order is preserved.

Source files
------------

// File: rtl/bp_fe_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bp_fe_pkg: FE command opcodes, exception codes, FSM states and the     |
// | fetch-buffer entry layout.                  Revision: 1.0              |
// +-----------------------------------------------------------------------+
package bp_fe_pkg;

  typedef enum logic [2:0] {
    e_op_state_reset          = 3'd0,
    e_op_pc_redirection       = 3'd1,
    e_op_icache_fill_response = 3'd2,
    e_op_branch_update        = 3'd3,
    e_op_attaboy              = 3'd4,
    e_op_icache_fence         = 3'd5,
    e_op_itlb_fill_response   = 3'd6,
    e_op_itlb_fence           = 3'd7
  } bp_fe_command_e;

  typedef enum logic [1:0] {
    e_itlb_miss          = 2'd0,
    e_icache_miss        = 2'd1,
    e_instr_page_fault   = 2'd2,
    e_instr_access_fault = 2'd3
  } bp_fe_exc_e;

  typedef enum logic {
    e_wait = 1'b0,
    e_run  = 1'b1
  } bp_fe_state_e;

  localparam int c_vaddr_width_dflt = 39;
  localparam int c_instr_width_dflt = 32;
  localparam int c_exc_width_dflt   = 2;

  // Entry layout at the default widths; the buffer stores the same field order flattened.
  typedef struct packed {
    logic [c_vaddr_width_dflt-1:0] pc;
    logic [c_instr_width_dflt-1:0] instr;
    logic                          exc_v;
    logic [c_exc_width_dflt-1:0]   exc_code;
  } bp_fe_entry_s;

  function automatic int f_entry_width(input int vaddr_w, input int instr_w, input int exc_w);
    return vaddr_w + instr_w + 1 + exc_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_fe_fetch_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bp_fe_fetch_buffer: circular buffer, up to WR_ELS writes and one read  |
// | per cycle, with flush.                      Revision: 1.0              |
// +-----------------------------------------------------------------------+
module bp_fe_fetch_buffer #(
  parameter int WIDTH  = 74,
  parameter int ELS    = 8,
  parameter int WR_ELS = 2
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  input  logic [$clog2(WR_ELS+1)-1:0]  wr_count_i,
  input  logic [WR_ELS*WIDTH-1:0]      wr_data_i,
  input  logic                         rd_yumi_i,
  output logic [WIDTH-1:0]             rd_data_o,
  output logic [$clog2(ELS+1)-1:0]     count_o
);

  localparam int c_ptr_w = (ELS > 1) ? $clog2(ELS) : 1;
  localparam int c_cnt_w = $clog2(ELS + 1);

  logic [WIDTH-1:0]   r_mem [ELS];
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_cnt_w-1:0] r_count;
  int                 w_count_sum;

  // Pointer sums never exceed 2*ELS-1, so a single conditional subtract wraps them.
  function automatic logic [c_ptr_w-1:0] f_wrap(input int v);
    return c_ptr_w'((v >= ELS) ? v - ELS : v);
  endfunction

  always_comb begin
    w_count_sum = int'(r_count) + int'(wr_count_i) - (rd_yumi_i ? 1 : 0);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      assert (w_count_sum >= 0 && w_count_sum <= ELS);
      r_wptr  <= f_wrap(int'(r_wptr) + int'(wr_count_i));
      r_rptr  <= rd_yumi_i ? f_wrap(int'(r_rptr) + 1) : r_rptr;
      r_count <= c_cnt_w'(w_count_sum);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      for (int i = 0; i < WR_ELS; i++) begin
        if (i < int'(wr_count_i)) begin
          r_mem[f_wrap(int'(r_wptr) + i)] <= wr_data_i[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign rd_data_o = r_mem[r_rptr];
  assign count_o   = r_count;

endmodule
`default_nettype wire

// File: rtl/bp_fe_fetch_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bp_fe_fetch_ctrl: credit-based FE fetch control with epoch filtering   |
// | and packet-to-instruction splitting.        Revision: 1.0              |
// +-----------------------------------------------------------------------+
module bp_fe_fetch_ctrl
  import bp_fe_pkg::*;
#(
  parameter int vaddr_width_p     = 39,
  parameter int instr_width_p     = 32,
  parameter int fetch_width_p     = 2,
  parameter int queue_els_p       = 8,
  parameter int max_outstanding_p = 2,
  parameter int exc_code_width_p  = 2
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  cmd_v_i,
  input  logic [2:0]                            cmd_opcode_i,
  input  logic [vaddr_width_p-1:0]              cmd_pc_i,
  output logic                                  cmd_yumi_o,
  output logic                                  fetch_v_o,
  output logic [vaddr_width_p-1:0]              fetch_pc_o,
  output logic                                  fetch_epoch_o,
  input  logic                                  fetch_yumi_i,
  input  logic                                  resp_v_i,
  input  logic                                  resp_epoch_i,
  input  logic [vaddr_width_p-1:0]              resp_pc_i,
  input  logic [fetch_width_p*instr_width_p-1:0] resp_instr_i,
  input  logic [$clog2(fetch_width_p+1)-1:0]    resp_count_i,
  input  logic                                  resp_exc_v_i,
  input  logic [exc_code_width_p-1:0]           resp_exc_code_i,
  output logic                                  fe_queue_v_o,
  output logic [vaddr_width_p-1:0]              fe_queue_pc_o,
  output logic [instr_width_p-1:0]              fe_queue_instr_o,
  output logic                                  fe_queue_exc_v_o,
  output logic [exc_code_width_p-1:0]           fe_queue_exc_code_o,
  input  logic                                  fe_queue_yumi_i
);

  localparam int c_entry_w = f_entry_width(vaddr_width_p, instr_width_p, exc_code_width_p);
  localparam int c_cnt_w   = $clog2(queue_els_p + 1);
  localparam int c_out_w   = $clog2(max_outstanding_p + 1);
  localparam int c_rc_w    = $clog2(fetch_width_p + 1);
  localparam int c_align   = 4 * fetch_width_p;

  bp_fe_state_e                   r_state;
  logic [vaddr_width_p-1:0]       r_pc;
  logic                           r_epoch;
  logic [c_out_w-1:0]             r_out;

  logic                           w_redirect;
  logic                           w_is_run;
  logic                           w_credit_ok;
  logic                           w_fetch_acc;
  logic                           w_resp_acc;
  logic                           w_deq;
  logic [c_cnt_w-1:0]             w_count;
  logic [c_rc_w-1:0]              w_wr_count;
  logic [fetch_width_p*c_entry_w-1:0] w_wr_data;
  logic [c_entry_w-1:0]           w_rd_data;

  assign w_redirect  = cmd_v_i & (bp_fe_command_e'(cmd_opcode_i) != e_op_attaboy);
  assign w_is_run    = (r_state == e_run);
  assign cmd_yumi_o  = cmd_v_i;

  // Reserve a full packet of space for every fetch in flight plus the one being issued.
  assign w_credit_ok = (int'(w_count) + fetch_width_p * (int'(r_out) + 1)) <= queue_els_p;
  assign fetch_v_o   = w_is_run & ~w_redirect & (int'(r_out) < max_outstanding_p) & w_credit_ok;
  assign fetch_pc_o  = r_pc;
  assign fetch_epoch_o = r_epoch;
  assign w_fetch_acc = fetch_v_o & fetch_yumi_i;

  assign w_resp_acc  = resp_v_i & (resp_epoch_i == r_epoch) & ~w_redirect & w_is_run;
  assign fe_queue_v_o = (w_count != '0) & ~w_redirect;
  assign w_deq       = fe_queue_yumi_i & fe_queue_v_o;

  always_comb begin
    w_wr_data  = '0;
    w_wr_count = '0;
    if (w_resp_acc) begin
      if (resp_exc_v_i) begin
        w_wr_count = c_rc_w'(1);
        w_wr_data[0 +: c_entry_w] = {resp_pc_i, {instr_width_p{1'b0}}, 1'b1, resp_exc_code_i};
      end else begin
        w_wr_count = resp_count_i;
        for (int i = 0; i < fetch_width_p; i++) begin
          w_wr_data[i*c_entry_w +: c_entry_w] =
            {resp_pc_i + vaddr_width_p'(4 * i), resp_instr_i[i*instr_width_p +: instr_width_p],
             1'b0, {exc_code_width_p{1'b0}}};
        end
      end
    end
  end

  bp_fe_fetch_buffer #(
    .WIDTH  (c_entry_w),
    .ELS    (queue_els_p),
    .WR_ELS (fetch_width_p)
  ) u_buf (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .flush_i    (w_redirect),
    .wr_count_i (w_wr_count),
    .wr_data_i  (w_wr_data),
    .rd_yumi_i  (w_deq),
    .rd_data_o  (w_rd_data),
    .count_o    (w_count)
  );

  assign {fe_queue_pc_o, fe_queue_instr_o, fe_queue_exc_v_o, fe_queue_exc_code_o} = w_rd_data;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= e_wait;
      r_pc    <= '0;
      r_epoch <= 1'b0;
      r_out   <= '0;
    end else begin
      if (w_redirect) begin
        r_state <= e_run;
        r_pc    <= cmd_pc_i;
        r_epoch <= ~r_epoch;
      end else begin
        if (w_fetch_acc) begin
          r_pc <= (r_pc & ~vaddr_width_p'(c_align - 1)) + vaddr_width_p'(c_align);
        end
        if (w_resp_acc & resp_exc_v_i) begin
          r_state <= e_wait;
        end
      end
      // Stale responses still return their credit.
      case ({w_fetch_acc, resp_v_i})
        2'b10:   r_out <= r_out + c_out_w'(1);
        2'b01:   r_out <= r_out - c_out_w'(1);
        default: r_out <= r_out;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bp_fe_fetch_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_bp_fe_fetch_ctrl: directed scoreboard bench for bp_fe_fetch_ctrl.   |
// |                                             Revision: 1.0              |
// +-----------------------------------------------------------------------+
module tb_bp_fe_fetch_ctrl;
  import bp_fe_pkg::*;

  localparam int VW = 39;
  localparam int IW = 32;
  localparam int FW = 2;
  localparam int QE = 8;
  localparam int MO = 2;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          cmd_v_i;
  logic [2:0]    cmd_opcode_i;
  logic [VW-1:0] cmd_pc_i;
  logic          cmd_yumi_o;
  logic          fetch_v_o;
  logic [VW-1:0] fetch_pc_o;
  logic          fetch_epoch_o;
  logic          fetch_yumi_i;
  logic          resp_v_i;
  logic          resp_epoch_i;
  logic [VW-1:0] resp_pc_i;
  logic [FW*IW-1:0] resp_instr_i;
  logic [1:0]    resp_count_i;
  logic          resp_exc_v_i;
  logic [EW-1:0] resp_exc_code_i;
  logic          fe_queue_v_o;
  logic [VW-1:0] fe_queue_pc_o;
  logic [IW-1:0] fe_queue_instr_o;
  logic          fe_queue_exc_v_o;
  logic [EW-1:0] fe_queue_exc_code_o;
  logic          fe_queue_yumi_i;

  always #5 clk = ~clk;

  bp_fe_fetch_ctrl #(
    .vaddr_width_p(VW), .instr_width_p(IW), .fetch_width_p(FW),
    .queue_els_p(QE), .max_outstanding_p(MO), .exc_code_width_p(EW)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .cmd_v_i(cmd_v_i), .cmd_opcode_i(cmd_opcode_i), .cmd_pc_i(cmd_pc_i), .cmd_yumi_o(cmd_yumi_o),
    .fetch_v_o(fetch_v_o), .fetch_pc_o(fetch_pc_o), .fetch_epoch_o(fetch_epoch_o),
    .fetch_yumi_i(fetch_yumi_i),
    .resp_v_i(resp_v_i), .resp_epoch_i(resp_epoch_i), .resp_pc_i(resp_pc_i),
    .resp_instr_i(resp_instr_i), .resp_count_i(resp_count_i),
    .resp_exc_v_i(resp_exc_v_i), .resp_exc_code_i(resp_exc_code_i),
    .fe_queue_v_o(fe_queue_v_o), .fe_queue_pc_o(fe_queue_pc_o), .fe_queue_instr_o(fe_queue_instr_o),
    .fe_queue_exc_v_o(fe_queue_exc_v_o), .fe_queue_exc_code_o(fe_queue_exc_code_o),
    .fe_queue_yumi_i(fe_queue_yumi_i)
  );

  typedef struct {
    logic [VW-1:0] pc;
    logic [IW-1:0] instr;
    logic          exc_v;
    logic [EW-1:0] code;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag);
    exp_t e;
    chk({tag, "_v"}, {63'd0, fe_queue_v_o}, 64'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_pc"},    64'(fe_queue_pc_o),       64'(e.pc));
      chk({tag, "_instr"}, 64'(fe_queue_instr_o),    64'(e.instr));
      chk({tag, "_exc"},   64'(fe_queue_exc_v_o),    64'(e.exc_v));
      chk({tag, "_code"},  64'(fe_queue_exc_code_o), 64'(e.code));
    end
  endtask

  task automatic deq_one(input string tag);
    #1;
    check_head(tag);
    fe_queue_yumi_i = 1'b1;
    tick();
    fe_queue_yumi_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    #1;
    while (fe_queue_v_o === 1'b1 && g < 16) begin
      deq_one(tag);
      #1;
      g++;
    end
    chk({tag, "_left"}, 64'(sb.size()), 64'd0);
    chk({tag, "_cnt"},  64'(dut.w_count), 64'd0);
  endtask

  task automatic do_fetch(input string tag, input logic [VW-1:0] pc);
    #1;
    chk({tag, "_fv"}, {63'd0, fetch_v_o}, 64'd1);
    chk({tag, "_pc"}, 64'(fetch_pc_o), 64'(pc));
    fetch_yumi_i = 1'b1;
    tick();
    fetch_yumi_i = 1'b0;
  endtask

  task automatic drive_resp(input logic ep, input logic [VW-1:0] pc, input logic [1:0] cnt,
                            input logic [IW-1:0] i0, input logic [IW-1:0] i1,
                            input logic exc, input logic [EW-1:0] code, input logic push);
    exp_t e;
    resp_v_i        = 1'b1;
    resp_epoch_i    = ep;
    resp_pc_i       = pc;
    resp_count_i    = cnt;
    resp_instr_i    = {i1, i0};
    resp_exc_v_i    = exc;
    resp_exc_code_i = code;
    if (push) begin
      if (exc) begin
        e.pc = pc; e.instr = '0; e.exc_v = 1'b1; e.code = code;
        sb.push_back(e);
      end else begin
        e.pc = pc; e.instr = i0; e.exc_v = 1'b0; e.code = '0;
        sb.push_back(e);
        if (cnt == 2'd2) begin
          e.pc = pc + 4; e.instr = i1;
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic do_resp(input logic ep, input logic [VW-1:0] pc, input logic [1:0] cnt,
                         input logic [IW-1:0] i0, input logic [IW-1:0] i1,
                         input logic exc, input logic [EW-1:0] code, input logic push);
    drive_resp(ep, pc, cnt, i0, i1, exc, code, push);
    tick();
    resp_v_i     = 1'b0;
    resp_exc_v_i = 1'b0;
  endtask

  task automatic redirect(input string tag, input logic [VW-1:0] pc);
    cmd_v_i      = 1'b1;
    cmd_opcode_i = e_op_pc_redirection;
    cmd_pc_i     = pc;
    #1;
    chk({tag, "_fv0"},  {63'd0, fetch_v_o},    64'd0);
    chk({tag, "_qv0"},  {63'd0, fe_queue_v_o}, 64'd0);
    chk({tag, "_yumi"}, {63'd0, cmd_yumi_o},   64'd1);
    tick();
    cmd_v_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b1; cmd_v_i = 1'b1; cmd_opcode_i = e_op_pc_redirection; cmd_pc_i = 39'h1234;
    fetch_yumi_i = 1'b0; resp_v_i = 1'b0; resp_epoch_i = 1'b0; resp_pc_i = '0;
    resp_instr_i = '0; resp_count_i = 2'd0; resp_exc_v_i = 1'b0; resp_exc_code_i = '0;
    fe_queue_yumi_i = 1'b0;

    // Reset
    tick(); tick();
    chk("rst_fv",   {63'd0, fetch_v_o},    64'd0);
    chk("rst_qv",   {63'd0, fe_queue_v_o}, 64'd0);
    chk("rst_yumi", {63'd0, cmd_yumi_o},   64'd1);
    chk("rst_cnt",  64'(dut.w_count),      64'd0);
    chk("rst_out",  64'(dut.r_out),        64'd0);
    chk("rst_pc",   64'(fetch_pc_o),       64'd0);
    cmd_v_i = 1'b0;
    #1;
    chk("rst_yumi0", {63'd0, cmd_yumi_o}, 64'd0);
    reset_i = 1'b0;
    tick();

    // T1: redirect, two fetches, stall on outstanding limit
    redirect("t1_redir", 39'h8000_0000);
    do_fetch("t1_f0", 39'h8000_0000);
    chk("t1_epoch", {63'd0, fetch_epoch_o}, 64'd1);
    do_fetch("t1_f1", 39'h8000_0008);
    fetch_yumi_i = 1'b1;
    #1;
    chk("t1_stall0", {63'd0, fetch_v_o}, 64'd0);
    tick();
    chk("t1_stall1", {63'd0, fetch_v_o}, 64'd0);
    chk("t1_stallpc", 64'(fetch_pc_o), 64'h8000_0010);
    fetch_yumi_i = 1'b0;
    do_resp(1'b1, 39'h8000_0000, 2'd2, 32'hA0, 32'hA1, 1'b0, '0, 1'b1);
    do_resp(1'b1, 39'h8000_0008, 2'd2, 32'hA2, 32'hA3, 1'b0, '0, 1'b1);
    #1;
    chk("t1_cnt", 64'(dut.w_count), 64'd4);
    chk("t1_out", 64'(dut.r_out),   64'd0);
    drain("t1_drain");

    // T2: misaligned redirect, single-lane response
    redirect("t2_redir", 39'h8000_0004);
    do_fetch("t2_f0", 39'h8000_0004);
    #1;
    chk("t2_realign", 64'(fetch_pc_o), 64'h8000_0008);
    do_resp(1'b0, 39'h8000_0004, 2'd1, 32'h13, 32'hDEAD, 1'b0, '0, 1'b1);
    #1;
    chk("t2_cnt", 64'(dut.w_count), 64'd1);
    drain("t2_drain");

    // T3: fill buffer to capacity with consumer stalled
    for (int k = 0; k < 4; k++) begin
      do_fetch("t3_f", 39'h8000_0008 + 39'(8 * k));
      do_resp(1'b0, 39'h8000_0008 + 39'(8 * k), 2'd2,
              32'h100 + 32'(2 * k), 32'h101 + 32'(2 * k), 1'b0, '0, 1'b1);
    end
    #1;
    chk("t3_cnt8", 64'(dut.w_count), 64'd8);
    chk("t3_fv8",  {63'd0, fetch_v_o}, 64'd0);
    cmd_v_i = 1'b1; cmd_opcode_i = e_op_attaboy; cmd_pc_i = 39'h7777_0000;
    #1;
    chk("t3_aby_yumi", {63'd0, cmd_yumi_o},   64'd1);
    chk("t3_aby_qv",   {63'd0, fe_queue_v_o}, 64'd1);
    tick();
    cmd_v_i = 1'b0;
    #1;
    chk("t3_aby_cnt", 64'(dut.w_count), 64'd8);
    chk("t3_aby_pc",  64'(fetch_pc_o),  64'h8000_0028);
    deq_one("t3_d0");
    #1;
    chk("t3_cnt7", 64'(dut.w_count),   64'd7);
    chk("t3_fv7",  {63'd0, fetch_v_o}, 64'd0);
    deq_one("t3_d1");
    #1;
    chk("t3_cnt6", 64'(dut.w_count),   64'd6);
    chk("t3_fv6",  {63'd0, fetch_v_o}, 64'd1);
    drain("t3_drain");

    // T4: redirect with two fetches in flight; stale responses dropped
    do_fetch("t4_f0", 39'h8000_0028);
    do_fetch("t4_f1", 39'h8000_0030);
    redirect("t4_redir", 39'h9000_0000);
    #1;
    chk("t4_pc",    64'(fetch_pc_o), 64'h9000_0000);
    chk("t4_out2",  64'(dut.r_out),  64'd2);
    do_resp(1'b0, 39'h8000_0028, 2'd2, 32'hBAD0, 32'hBAD1, 1'b0, '0, 1'b0);
    do_resp(1'b0, 39'h8000_0030, 2'd2, 32'hBAD2, 32'hBAD3, 1'b0, '0, 1'b0);
    #1;
    chk("t4_cnt", 64'(dut.w_count),      64'd0);
    chk("t4_out", 64'(dut.r_out),        64'd0);
    chk("t4_qv",  {63'd0, fe_queue_v_o}, 64'd0);
    do_fetch("t4_fnew", 39'h9000_0000);

    // T5: exception response drops to e_wait
    do_resp(1'b1, 39'h9000_0000, 2'd2, 32'h55, 32'h66, 1'b1, e_icache_miss, 1'b1);
    fetch_yumi_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_fv0", {63'd0, fetch_v_o}, 64'd0);
      tick();
    end
    fetch_yumi_i = 1'b0;
    chk("t5_cnt", 64'(dut.w_count), 64'd1);
    chk("t5_out", 64'(dut.r_out),   64'd0);
    drain("t5_drain");
    redirect("t5_redir", 39'hA000_0000);
    #1;
    chk("t5_fv1", {63'd0, fetch_v_o}, 64'd1);

    // T6: simultaneous enqueue of two and dequeue of one at count 5
    do_fetch("t6_f0", 39'hA000_0000);
    do_resp(1'b0, 39'hA000_0000, 2'd2, 32'hC0, 32'hC1, 1'b0, '0, 1'b1);
    do_fetch("t6_f1", 39'hA000_0008);
    do_resp(1'b0, 39'hA000_0008, 2'd2, 32'hC2, 32'hC3, 1'b0, '0, 1'b1);
    do_fetch("t6_f2", 39'hA000_0010);
    do_resp(1'b0, 39'hA000_0010, 2'd1, 32'hC4, 32'hFFFF, 1'b0, '0, 1'b1);
    #1;
    chk("t6_cnt5", 64'(dut.w_count), 64'd5);
    do_fetch("t6_f3", 39'hA000_0018);
    drive_resp(1'b0, 39'hA000_0018, 2'd2, 32'hC5, 32'hC6, 1'b0, '0, 1'b1);
    #1;
    check_head("t6_sim");
    fe_queue_yumi_i = 1'b1;
    tick();
    fe_queue_yumi_i = 1'b0;
    resp_v_i = 1'b0;
    #1;
    chk("t6_cnt6", 64'(dut.w_count), 64'd6);
    drain("t6_drain");

    // Asynchronous reset mid-operation
    do_fetch("ar_f0", 39'hA000_0020);
    do_resp(1'b0, 39'hA000_0020, 2'd2, 32'hD0, 32'hD1, 1'b0, '0, 1'b0);
    #2;
    reset_i = 1'b1;
    #1;
    chk("ar_cnt", 64'(dut.w_count),      64'd0);
    chk("ar_out", 64'(dut.r_out),        64'd0);
    chk("ar_fv",  {63'd0, fetch_v_o},    64'd0);
    chk("ar_qv",  {63'd0, fe_queue_v_o}, 64'd0);
    chk("ar_pc",  64'(fetch_pc_o),       64'd0);
    tick();
    reset_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
